uart_frame_loader: RTL and testbench



---
 rtl/uart_frame_loader.sv | 192 +++++++++++++++++++
 tb/tb_uart_frame_loader.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_loader.sv
// uart_frame_loader
// Assembles one frame from the UART byte stream: command byte, label byte,
// then IMG_BYTES pixel bytes. When complete it pulses start (and train for
// training frames) and holds label/image stable until the control unit acks.
// Bad command bytes pulse err; bytes arriving while a frame is outstanding
// are dropped and pulse overrun.
//
// Optional build macro FRAME_CHECKSUM_EN: after the last pixel one extra
// byte is expected, which must equal the XOR of command, label and all
// pixel bytes. A mismatch pulses err and abandons the frame.

module uart_frame_loader #(
  parameter int          IMG_BYTES = 784,
  parameter logic [7:0]  CMD_INFER = 8'hA5,
  parameter logic [7:0]  CMD_TRAIN = 8'h5A
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic                   ack,
  output logic                   start,
  output logic                   train,
  output logic [7:0]             label_out,
  output logic [IMG_BYTES*8-1:0] image_out,
  output logic                   busy,
  output logic                   err,
  output logic                   overrun
);

  // Counter holds 0..IMG_BYTES so it never wraps inside a frame.
  localparam int             CW       = $clog2(IMG_BYTES + 1);
  localparam logic [CW-1:0]  LAST_IDX = CW'(IMG_BYTES - 1);

`ifdef FRAME_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LABEL, S_PIXELS, S_CKSUM, S_ISSUE, S_WAIT_ACK
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LABEL, S_PIXELS, S_ISSUE, S_WAIT_ACK
  } state_t;
`endif

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            mode_q;      // 1 = training frame
  logic [7:0]      label_q;
  logic            start_q;
  logic            train_q;
  logic            busy_q;
  logic            err_q;
  logic            overrun_q;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]      xor_q;
`endif

  logic            pix_we;

  assign pix_we = rx_valid && (state_q == S_PIXELS);

  // Frame sequencing FSM with registered control outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      label_q   <= '0;
      start_q   <= 1'b0;
      train_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      overrun_q <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      xor_q     <= '0;
`endif
    end else begin
      // Pulse outputs default low; set only on the cycle that raises them.
      start_q   <= 1'b0;
      train_q   <= 1'b0;
      err_q     <= 1'b0;
      overrun_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
`ifdef FRAME_CHECKSUM_EN
          xor_q <= '0;
`endif
          if (rx_valid) begin
            if (rx_data == CMD_INFER || rx_data == CMD_TRAIN) begin
              mode_q  <= (rx_data == CMD_TRAIN);
              state_q <= S_LABEL;
`ifdef FRAME_CHECKSUM_EN
              xor_q   <= rx_data;
`endif
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_LABEL: begin
          if (rx_valid) begin
            label_q <= rx_data;
            cnt_q   <= '0;
            state_q <= S_PIXELS;
`ifdef FRAME_CHECKSUM_EN
            xor_q   <= xor_q ^ rx_data;
`endif
          end
        end
        S_PIXELS: begin
          if (rx_valid) begin
            cnt_q <= cnt_q + 1'b1;
`ifdef FRAME_CHECKSUM_EN
            xor_q <= xor_q ^ rx_data;
            if (cnt_q == LAST_IDX) begin
              state_q <= S_CKSUM;
            end
`else
            if (cnt_q == LAST_IDX) begin
              state_q <= S_ISSUE;
              start_q <= 1'b1;
              train_q <= mode_q;
              busy_q  <= 1'b1;
            end
`endif
          end
        end
`ifdef FRAME_CHECKSUM_EN
        S_CKSUM: begin
          if (rx_valid) begin
            if (rx_data == xor_q) begin
              state_q <= S_ISSUE;
              start_q <= 1'b1;
              train_q <= mode_q;
              busy_q  <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              err_q   <= 1'b1;
            end
          end
        end
`endif
        S_ISSUE: begin
          // ack is deliberately ignored in the start cycle.
          if (rx_valid) begin
            overrun_q <= 1'b1;
          end
          state_q <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          // A byte coinciding with the accepted ack is still dropped.
          if (rx_valid) begin
            overrun_q <= 1'b1;
          end
          if (ack) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // One register per pixel byte; only the addressed byte is written.
  for (genvar gi = 0; gi < IMG_BYTES; gi++) begin : g_pix
    localparam logic [CW-1:0] IDX = CW'(gi);
    logic [7:0] byte_q;

    // Capture this pixel when the counter points at it.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        byte_q <= '0;
      end else if (pix_we && cnt_q == IDX) begin
        byte_q <= rx_data;
      end
    end

    assign image_out[8*gi +: 8] = byte_q;
  end

  assign start     = start_q;
  assign train     = train_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign overrun   = overrun_q;
  assign label_out = label_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Testbench for uart_frame_loader: randomized byte stream checked every cycle
// against a byte-count based frame model, plus hand-computed literal checks.

module tb_uart_frame_loader;

  localparam int IMG = 784;
`ifdef FRAME_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [7:0]      rx_data = 8'h00;
  logic            rx_valid = 1'b0;
  logic            ack = 1'b0;
  logic            start, train, busy, err, overrun;
  logic [7:0]      label_out;
  logic [IMG*8-1:0] image_out;

  uart_frame_loader #(.IMG_BYTES(IMG)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .ack(ack), .start(start), .train(train), .label_out(label_out),
    .image_out(image_out), .busy(busy), .err(err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_idx counts frame bytes accepted so far (0 = waiting for a command).
  int          m_idx;
  bit          m_out, m_issue, m_mode, m_err, m_ovr;
  logic [7:0]  m_label, m_xor;
  logic [7:0]  m_img [IMG];
  logic [IMG*8-1:0] m_vec;
  logic        s_rv, s_ack, s_rst;
  logic [7:0]  s_rd;

  task automatic model_step();
    if (!s_rst) begin
      m_idx = 0; m_out = 0; m_issue = 0; m_mode = 0; m_err = 0; m_ovr = 0;
      m_label = 8'h00; m_xor = 8'h00;
      for (int i = 0; i < IMG; i++) m_img[i] = 8'h00;
      return;
    end
    m_err = 0;
    m_ovr = 0;
    if (m_issue) begin
      m_ovr   = s_rv;
      m_issue = 0;
    end else if (m_out) begin
      m_ovr = s_rv;
      if (s_ack) m_out = 0;
    end else if (s_rv) begin
      if (m_idx == 0) begin
        if (s_rd == 8'hA5 || s_rd == 8'h5A) begin
          m_mode = (s_rd == 8'h5A);
          m_xor  = s_rd;
          m_idx  = 1;
        end else begin
          m_err = 1;
        end
      end else if (m_idx == 1) begin
        m_label = s_rd;
        m_xor   = m_xor ^ s_rd;
        m_idx   = 2;
      end else if (m_idx < IMG + 2) begin
        m_img[m_idx-2] = s_rd;
        m_xor = m_xor ^ s_rd;
        m_idx++;
        if (m_idx == IMG + 2 && !CK) begin
          m_idx = 0; m_issue = 1; m_out = 1;
        end
      end else begin
        if (s_rd == m_xor) begin
          m_issue = 1; m_out = 1;
        end else begin
          m_err = 1;
        end
        m_idx = 0;
      end
    end
  endtask

  // Per-cycle compare against the model, sampled 1 ns after the edge.
  always @(posedge clk) begin
    s_rv = rx_valid; s_rd = rx_data; s_ack = ack; s_rst = rst_n;
    model_step();
    #1;
    for (int i = 0; i < IMG; i++) m_vec[8*i +: 8] = m_img[i];
    chk("start",   start,   m_issue);
    chk("train",   train,   m_issue & m_mode);
    chk("busy",    busy,    m_issue | m_out);
    chk("err",     err,     m_err);
    chk("overrun", overrun, m_ovr);
    chk("label",   label_out, m_label);
    n_checks++;
    if (image_out !== m_vec) begin
      n_fail++;
      for (int i = 0; i < IMG; i++) begin
        if (image_out[8*i +: 8] !== m_vec[8*i +: 8]) begin
          $display("FAIL image: byte %0d got %0h expected %0h at %0t",
                   i, image_out[8*i +: 8], m_vec[8*i +: 8], $time);
          break;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] f_data [IMG];
  bit         rand_ack_en = 1'b0;

  // Called at a negedge; returns at the negedge after the byte's edge.
  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int g;
    g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    repeat (g) begin
      ack = rand_ack_en ? 1'($urandom_range(1, 0)) : 1'b0;
      @(negedge clk);
    end
    ack      = rand_ack_en ? 1'($urandom_range(1, 0)) : 1'b0;
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    ack      = 1'b0;
  endtask

  task automatic send_pixels(input int n, input int gap);
    for (int i = 0; i < n; i++) send_byte(f_data[i], gap);
  endtask

  function automatic logic [7:0] calc_xor(input logic [7:0] c, input logic [7:0] l);
    logic [7:0] x;
    x = c ^ l;
    for (int i = 0; i < IMG; i++) x = x ^ f_data[i];
    return x;
  endfunction

  task automatic send_frame(input logic [7:0] c, input logic [7:0] l, input int gap);
    send_byte(c, gap);
    send_byte(l, gap);
    send_pixels(IMG, gap);
    if (CK) send_byte(calc_xor(c, l), gap);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int ovr_cnt;
    logic [7:0] c;

    // Reset
    idle(3);
    rst_n = 1'b1;
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_label", label_out, 0);
    chk("rst_image", (image_out == '0), 1);

    // Test 1: inference frame, pixels i%256
    for (int i = 0; i < IMG; i++) f_data[i] = 8'(i % 256);
    send_frame(8'hA5, 8'h07, 2);
    chk("t1_start", start, 1);
    chk("t1_train", train, 0);
    chk("t1_busy", busy, 1);
    chk("t1_label", label_out, 8'h07);
    chk("t1_byte783", image_out[783*8 +: 8], 8'h0F);
    chk("t1_byte1", image_out[1*8 +: 8], 8'h01);
    idle(50);
    chk("t1_hold_busy", busy, 1);
    chk("t1_hold_byte783", image_out[783*8 +: 8], 8'h0F);
    pulse_ack();
    chk("t1_busy_drop", busy, 0);

    // Test 2: training frame, ack in the start cycle ignored
    for (int i = 0; i < IMG; i++) f_data[i] = 8'hFF;
    send_frame(8'h5A, 8'h03, 1);
    chk("t2_start", start, 1);
    chk("t2_train", train, 1);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("t2_start_once", start, 0);
    chk("t2_train_once", train, 0);
    chk("t2_busy_kept", busy, 1);
    idle(4);
    chk("t2_label", label_out, 8'h03);
    pulse_ack();
    chk("t2_busy_drop", busy, 0);

    // Test 3: bad command then valid frame
    send_byte(8'h11, 0);
    chk("t3_err", err, 1);
    chk("t3_busy", busy, 0);
    @(negedge clk);
    chk("t3_err_once", err, 0);
    for (int i = 0; i < IMG; i++) f_data[i] = 8'($urandom);
    send_frame(8'hA5, 8'h2C, 1);
    chk("t3_start", start, 1);
    chk("t3_label", label_out, 8'h2C);
    chk("t3_byte5", image_out[5*8 +: 8], f_data[5]);

    // Test 4: three bytes during WAIT_ACK
    idle(2);
    ovr_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      send_byte(8'($urandom), 0);
      if (overrun === 1'b1) ovr_cnt++;
      @(negedge clk);
    end
    chk("t4_overrun_count", ovr_cnt, 3);
    chk("t4_byte5_kept", image_out[5*8 +: 8], f_data[5]);
    pulse_ack();
    for (int i = 0; i < IMG; i++) f_data[i] = 8'($urandom);
    send_frame(8'h5A, 8'h99, 1);
    chk("t4_new_byte700", image_out[700*8 +: 8], f_data[700]);
    pulse_ack();

    // Test 5: reset after 400 pixels, then fresh frame
    for (int i = 0; i < IMG; i++) f_data[i] = 8'($urandom_range(255, 1));
    send_byte(8'hA5, 0);
    send_byte(8'h44, 0);
    send_pixels(400, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t5_rst_label", label_out, 0);
    chk("t5_rst_image", (image_out == '0), 1);
    chk("t5_rst_busy", busy, 0);
    for (int i = 0; i < IMG; i++) f_data[i] = 8'($urandom);
    send_frame(8'hA5, 8'h55, 1);
    chk("t5_start", start, 1);
    chk("t5_byte0", image_out[7:0], f_data[0]);
    pulse_ack();

    // Random frames with stray acks, bad commands and overrun bytes
    for (int k = 0; k < 4; k++) begin
      rand_ack_en = 1'b1;
      if ($urandom_range(3, 0) == 0) send_byte(8'($urandom_range(255, 0)), 2);
      c = ($urandom_range(1, 0) == 1) ? 8'hA5 : 8'h5A;
      for (int i = 0; i < IMG; i++) f_data[i] = 8'($urandom);
      send_frame(c, 8'($urandom), 2);
      rand_ack_en = 1'b0;
      ack = 1'b0;
      repeat ($urandom_range(3, 0)) send_byte(8'($urandom), 2);
      idle($urandom_range(5, 0));
      pulse_ack();
    end

`ifdef FRAME_CHECKSUM_EN
    // Checksum: correct byte issues, wrong byte errors without start
    for (int i = 0; i < IMG; i++) f_data[i] = 8'h00;
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_pixels(IMG, 0);
    send_byte(8'hA4, 0);
    chk("ck_good_start", start, 1);
    pulse_ack();
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_pixels(IMG, 0);
    send_byte(8'h00, 0);
    chk("ck_bad_err", err, 1);
    chk("ck_bad_start", start, 0);
    chk("ck_bad_busy", busy, 0);
    send_byte(8'h11, 0);
    chk("ck_back_idle", err, 1);
`endif

    idle(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
